// File: rtl/demux_striping_lanes_if.sv
`default_nettype none
// ============================================================================
//  Module   : demux_striping_lanes_if
//  Brief    : Bus bundle for the round-robin striping demultiplexer: the
//             upstream valid/ready word stream, realign control and the
//             per-lane FWFT outputs with their backpressure.
//  Revision : 1.0  initial release
// ============================================================================
interface demux_striping_lanes_if #(
  parameter int DATA_W = 32,
  parameter int LANES  = 4
);
  localparam int LW = $clog2(LANES + 1);
  localparam int PW = $clog2(LANES);

  logic [DATA_W-1:0]       data_in;
  logic                    valid_in;
  logic                    ready_in;
  logic                    realign;
  logic [LW-1:0]           lanes_active;
  logic [LANES*DATA_W-1:0] data_out;
  logic [LANES-1:0]        valid_out;
  logic [LANES-1:0]        ready_out;
  logic [PW-1:0]           lane_ptr;

  // Environment side: produces the word stream and consumes the lanes.
  modport master (
    output data_in, valid_in, realign, lanes_active, ready_out,
    input  ready_in, data_out, valid_out, lane_ptr
  );

  // Demultiplexer side.
  modport slave (
    input  data_in, valid_in, realign, lanes_active, ready_out,
    output ready_in, data_out, valid_out, lane_ptr
  );
endinterface
`default_nettype wire

// File: rtl/demux_striping_lanes.sv
`default_nettype none
// ============================================================================
//  Module   : demux_striping_lanes
//  Brief    : Round-robin striping demultiplexer. Word k of the input stream
//             goes to lane (k mod active lanes); every lane owns a FWFT FIFO
//             with independent backpressure.
//  Revision : 1.0  initial release
// ============================================================================
module demux_striping_lanes #(
  parameter int DATA_W = 32,
  parameter int LANES  = 4,
  parameter int DEPTH  = 4
) (
  input  wire logic               clk_2f,
  input  wire logic               reset,
  demux_striping_lanes_if.slave   bus
);
  localparam int LW = $clog2(LANES + 1);
  localparam int PW = $clog2(LANES);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    r_lane_ptr;
  logic [LW-1:0]    r_active;
  logic [LW-1:0]    w_active_next;
  logic [LANES-1:0] w_full;
  logic [LANES-1:0] w_valid;
  logic [LANES-1:0] w_push;
  logic [LANES-1:0] w_pop;
  logic             w_accept;
  logic             w_last;

  // Only the target lane's fullness gates input; it is purely registered,
  // so ready_in has no path from valid_in or ready_out.
  assign bus.ready_in  = !w_full[r_lane_ptr];
  assign w_accept      = bus.valid_in && bus.ready_in;
  assign w_last        = (LW'(r_lane_ptr) == (r_active - LW'(1)));
  assign bus.lane_ptr  = r_lane_ptr;
  assign bus.valid_out = w_valid;

  // Clamp the requested lane count into 1..LANES.
  always_comb begin
    w_active_next = bus.lanes_active;
    if (bus.lanes_active == '0) begin
      w_active_next = LW'(1);
    end else if (bus.lanes_active > LW'(LANES)) begin
      w_active_next = LW'(LANES);
    end
  end

  // Rotation pointer and active lane count; realign wins over advance.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      r_lane_ptr <= '0;
      r_active   <= LW'(LANES);
    end else if (bus.realign) begin
      r_lane_ptr <= '0;
      r_active   <= w_active_next;
    end else if (w_accept) begin
      r_lane_ptr <= w_last ? '0 : r_lane_ptr + PW'(1);
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr;
    logic [AW-1:0]     r_rd;
    logic [CW-1:0]     r_cnt;

    assign w_push[i]  = w_accept && (r_lane_ptr == PW'(i));
    assign w_pop[i]   = w_valid[i] && bus.ready_out[i];
    assign w_valid[i] = (r_cnt != '0);
    assign w_full[i]  = (r_cnt == CW'(DEPTH));
    assign bus.data_out[i*DATA_W +: DATA_W] = w_valid[i] ? r_mem[r_rd] : '0;

    // Storage needs no reset: the count masks stale entries.
    always_ff @(posedge clk_2f) begin
      if (w_push[i]) begin
        r_mem[r_wr] <= bus.data_in;
      end
    end

    // FIFO pointers and occupancy; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk_2f) begin
      if (reset) begin
        r_wr  <= '0;
        r_rd  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_push[i]) begin
          r_wr <= r_wr + AW'(1);
        end
        if (w_pop[i]) begin
          r_rd <= r_rd + AW'(1);
        end
        if (w_push[i] && !w_pop[i]) begin
          r_cnt <= r_cnt + CW'(1);
        end else if (!w_push[i] && w_pop[i]) begin
          r_cnt <= r_cnt - CW'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_demux_striping_lanes.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux_striping_lanes
//  Brief    : Self-checking bench for demux_striping_lanes: directed tables,
//             multi-cycle corner sequences and a randomised run against a
//             per-lane queue scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_demux_striping_lanes;
  localparam int DW    = 32;
  localparam int NL    = 4;
  localparam int DEPTH = 4;

  logic clk_2f = 1'b0;
  logic reset  = 1'b0;
  always #5 clk_2f = ~clk_2f;

  demux_striping_lanes_if #(.DATA_W(DW), .LANES(NL)) bus ();

  demux_striping_lanes #(.DATA_W(DW), .LANES(NL), .DEPTH(DEPTH)) dut (
    .clk_2f (clk_2f),
    .reset  (reset),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] data;
    int          lane;
  } word_vec_t;

  typedef struct {
    logic [2:0] la;
    int         n;
  } realign_vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_q [NL][$];
  int          m_ptr = 0;
  int          m_act = NL;
  bit          m_known = 1'b0;
  bit          last_acc = 1'b0;
  logic [31:0] next_w = 32'h100;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_data(input int i);
    return bus.data_out[i*DW +: DW];
  endfunction

  // Compare every visible output against the scoreboard state.
  task automatic check_model();
    if (!m_known) return;
    chk("ready_in", 128'(bus.ready_in), 128'(m_q[m_ptr].size() < DEPTH));
    chk("lane_ptr", 128'(bus.lane_ptr), 128'(m_ptr));
    for (int i = 0; i < NL; i++) begin
      chk($sformatf("valid_out[%0d]", i), 128'(bus.valid_out[i]), 128'(m_q[i].size() > 0));
      chk($sformatf("data_out[%0d]", i), 128'(lane_data(i)),
          128'((m_q[i].size() > 0) ? m_q[i][0] : 32'h0));
    end
  endtask

  // One clock: drive, check current outputs, update scoreboard, advance.
  task automatic step(input logic v, input logic [31:0] d, input logic [3:0] ro,
                      input logic ra = 1'b0, input logic [2:0] la = 3'd0,
                      input logic rs = 1'b0);
    bit acc;
    bus.valid_in     = v;
    bus.data_in      = d;
    bus.ready_out    = ro;
    bus.realign      = ra;
    bus.lanes_active = la;
    reset            = rs;
    check_model();
    if (rs) begin
      for (int i = 0; i < NL; i++) m_q[i].delete();
      m_ptr   = 0;
      m_act   = NL;
      m_known = 1'b1;
      acc     = 1'b0;
    end else begin
      acc = v && (m_q[m_ptr].size() < DEPTH);
      for (int i = 0; i < NL; i++) begin
        if (ro[i] && m_q[i].size() > 0) void'(m_q[i].pop_front());
      end
      if (acc) m_q[m_ptr].push_back(d);
      if (ra) begin
        m_ptr = 0;
        m_act = (la == 3'd0) ? 1 : ((int'(la) > NL) ? NL : int'(la));
      end else if (acc) begin
        m_ptr = (m_ptr == m_act - 1) ? 0 : m_ptr + 1;
      end
    end
    last_acc = acc;
    @(posedge clk_2f);
    @(negedge clk_2f);
  endtask

  task automatic send(input logic [3:0] ro);
    step(1'b1, next_w, ro);
    if (last_acc) next_w++;
  endtask

  word_vec_t    t1 [8];
  realign_vec_t t4 [3];

  initial begin
    for (int k = 0; k < 8; k++) t1[k] = '{32'hA0 + 32'(k), k % 4};
    t4[0] = '{3'd0, 1};
    t4[1] = '{3'd7, 4};
    t4[2] = '{3'd3, 3};

    bus.valid_in = 1'b0; bus.data_in = '0; bus.ready_out = '0;
    bus.realign = 1'b0; bus.lanes_active = '0;
    @(negedge clk_2f);
    step(1'b0, 32'h0, 4'h0, 1'b0, 3'd0, 1'b1);
    step(1'b0, 32'h0, 4'h0, 1'b0, 3'd0, 1'b1);

    // Reset state.
    chk("rst_ready_in", 128'(bus.ready_in), 128'(1'b1));
    chk("rst_lane_ptr", 128'(bus.lane_ptr), 128'(0));
    chk("rst_valid_out", 128'(bus.valid_out), 128'(0));
    chk("rst_data_out", 128'(bus.data_out), 128'(0));

    // Basic striping A0..A7, one-cycle latency.
    for (int k = 0; k < 8; k++) begin
      chk("t1_lane_ptr", 128'(bus.lane_ptr), 128'(t1[k].lane));
      step(1'b1, t1[k].data, 4'hF);
      chk("t1_valid", 128'(bus.valid_out[t1[k].lane]), 128'(1'b1));
      chk("t1_data", 128'(lane_data(t1[k].lane)), 128'(t1[k].data));
    end
    step(1'b0, 32'h0, 4'hF);
    chk("t1_end_ptr", 128'(bus.lane_ptr), 128'(0));

    // Lane 2 blocked: fills, stalls input at lane_ptr=2.
    for (int c = 0; c < 20; c++) send(4'b1011);
    chk("t2_ready_low", 128'(bus.ready_in), 128'(1'b0));
    chk("t2_ptr_stuck", 128'(bus.lane_ptr), 128'(2));
    step(1'b1, next_w, 4'b1111);
    chk("t2_no_passthru", 128'(last_acc), 128'(1'b0));
    chk("t2_ready_back", 128'(bus.ready_in), 128'(1'b1));
    for (int c = 0; c < 12; c++) send(4'hF);
    for (int c = 0; c < 6; c++) step(1'b0, 32'h0, 4'hF);

    // Realign to 2 lanes mid-stream from lane_ptr=3.
    for (int c = 0; c < 8 && m_ptr != 3; c++) send(4'b0011);
    chk("t3_pre_ptr", 128'(bus.lane_ptr), 128'(3));
    step(1'b1, next_w, 4'b0011, 1'b1, 3'd2);
    if (last_acc) next_w++;
    for (int k = 0; k < 6; k++) begin
      chk("t3_rot", 128'(bus.lane_ptr), 128'(k % 2));
      send(4'hF);
    end
    for (int c = 0; c < 6; c++) step(1'b0, 32'h0, 4'hF);
    chk("t3_drained", 128'(bus.valid_out), 128'(0));

    // Realign clamping table.
    for (int r = 0; r < 3; r++) begin
      step(1'b0, 32'h0, 4'hF, 1'b1, t4[r].la);
      for (int k = 0; k < 6; k++) begin
        chk("t4_rot", 128'(bus.lane_ptr), 128'(k % t4[r].n));
        send(4'hF);
      end
    end

    // Reset with words queued and valid_in high.
    step(1'b0, 32'h0, 4'hF, 1'b1, 3'd4);
    for (int k = 0; k < 12; k++) send(4'h0);
    chk("t5_all_valid", 128'(bus.valid_out), 128'(4'hF));
    step(1'b1, next_w, 4'hF, 1'b1, 3'd1, 1'b1);
    chk("t5_valid_out", 128'(bus.valid_out), 128'(0));
    chk("t5_data_out", 128'(bus.data_out), 128'(0));
    chk("t5_lane_ptr", 128'(bus.lane_ptr), 128'(0));
    step(1'b0, 32'h0, 4'hF);
    chk("t5_still_empty", 128'(bus.valid_out), 128'(0));

    // Random traffic against the scoreboard.
    for (int c = 0; c < 10000; c++) begin
      step(1'($urandom_range(0, 1)), $urandom, 4'($urandom),
           1'($urandom_range(0, 63) == 0), 3'($urandom_range(0, 7)));
    end
    for (int c = 0; c < 8; c++) step(1'b0, 32'h0, 4'hF);
    chk("t6_drained", 128'(bus.valid_out), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
